// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryption datapath, one full round per clock
module aes_round_engine #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] data_in,
    input  logic [0:127] round_key,
    output logic [3:0]   round_idx,
    output logic [0:127] sbox_in,
    input  logic [0:127] sbox_out,
    output logic [0:127] data_out,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, ROUND} fsm_t;
    fsm_t         fsm_q;
    logic [3:0]   cnt_q;
    logic [0:127] state_q, data_out_q, shifted, mixed, state_d;
    logic         busy_q, done_q;
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
        return o;
    endfunction
    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction
    assign sbox_in   = state_q;
    assign round_idx = cnt_q;
    assign data_out  = data_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    // Round transform on the S-box result; the final round omits MixColumns
    always_comb begin
        shifted = shift_rows(sbox_out);
        mixed   = mix_columns(shifted);
        state_d = (cnt_q == 4'(NR) ? shifted : mixed) ^ round_key;
    end
    // Control FSM with registered state, counter and handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q      <= IDLE;
            cnt_q      <= '0;
            state_q    <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= data_in ^ round_key;
                        cnt_q   <= 4'd1;
                        busy_q  <= 1'b1;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= state_d;
                    if (cnt_q == 4'(NR)) begin
                        data_out_q <= state_d;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        cnt_q      <= '0;
                        fsm_q      <= IDLE;
                    end else begin
                        done_q <= 1'b0;
                        cnt_q  <= cnt_q + 4'd1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: directed FIPS vectors plus random encryptions against a byte-matrix AES model
module tb_aes_round_engine;
    localparam int NR = 10;
    localparam logic [0:127] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset, start, busy, done;
    logic [0:127] data_in, round_key, sbox_in, sbox_out, data_out;
    logic [3:0]   round_idx;
    logic [0:127] rk [0:15];
    logic         ovr = 1'b0;
    logic [0:127] ovr_key = '0;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] sq = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        if (x == 8'h00) inv = 8'h00;
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [0:127] sub_bytes(input logic [0:127] x);
        logic [0:127] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(x[8*k +: 8]);
        return o;
    endfunction

    function automatic logic [0:127] round_key_of(input logic [0:127] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Whole-block AES-128 on a 4x4 row/column byte matrix
    function automatic logic [0:127] aes_ref(input logic [0:127] pt, input logic [0:127] key);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [0:127] k, o;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) s[j][c] = pt[8*(4*c+j) +: 8];
        for (int r = 0; r <= NR; r++) begin
            k = round_key_of(key, r);
            if (r > 0) begin
                for (int j = 0; j < 4; j++)
                    for (int c = 0; c < 4; c++) t[j][c] = sbox(s[j][(c+j)%4]);
                for (int j = 0; j < 4; j++)
                    for (int c = 0; c < 4; c++)
                        s[j][c] = (r < NR) ? gmul(t[j][c], 8'h02) ^ gmul(t[(j+1)%4][c], 8'h03)
                                             ^ t[(j+2)%4][c] ^ t[(j+3)%4][c]
                                           : t[j][c];
            end
            for (int j = 0; j < 4; j++)
                for (int c = 0; c < 4; c++) s[j][c] ^= k[8*(4*c+j) +: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) o[8*(4*c+j) +: 8] = s[j][c];
        return o;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    assign sbox_out  = sub_bytes(sbox_in);
    assign round_key = ovr ? ovr_key : rk[round_idx];

    aes_round_engine #(.NR(NR)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .round_key(round_key), .round_idx(round_idx), .sbox_in(sbox_in),
        .sbox_out(sbox_out), .data_out(data_out), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [0:127] obs, input logic [0:127] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [0:127] key);
        for (int r = 0; r < 16; r++) rk[r] = (r <= NR) ? round_key_of(key, r) : '0;
    endtask

    task automatic launch(input logic [0:127] pt, input logic [0:127] key);
        load_key(key);
        data_in = pt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int so_far, input logic [0:127] exp);
        int n = so_far;
        while (!done && n < NR + 10) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'(NR));
        chk({tag, " data_out"}, data_out, exp);
        chk({tag, " busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:127] held;
        logic [0:127] pk [3];
        logic [0:127] kk [3];
        int n, nd;
        reset = 1'b0;
        start = 1'b0;
        data_in = '0;
        load_key('0);
        #1 reset = 1'b1;
        #1;
        chk("rst data_out", data_out, '0);
        chk("rst sbox_in", sbox_in, '0);
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst done", 128'(done), 128'(0));
        chk("rst round_idx", 128'(round_idx), 128'(0));
        tick();
        tick();
        reset = 1'b0;
        tick();

        launch(P1, K1);
        chk("v1 sbox_in E0", sbox_in, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        chk("v1 round_idx E0", 128'(round_idx), 128'(1));
        wait_done("v1", 0, C1);
        tick();
        chk("v1 done clears", 128'(done), 128'(0));

        load_key(K2);
        data_in = P2;
        chk("v2 idle round_idx", 128'(round_idx), 128'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        nd = 0;
        for (int i = 1; i <= NR; i++) begin
            chk("v2 round_idx", 128'(round_idx), 128'(i));
            if (busy) nd++;
            tick();
        end
        chk("v2 busy cycles", 128'(nd), 128'(NR));
        chk("v2 done", 128'(done), 128'(1));
        chk("v2 round_idx end", 128'(round_idx), 128'(0));
        chk("v2 data_out", data_out, C2);
        tick();
        chk("v2 busy after", 128'(busy), 128'(0));

        launch(P1, K1);
        tick();
        tick();
        data_in = rand128();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("v3", 3, C1);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) nd++;
        end
        chk("v3 single done", 128'(nd), 128'(0));

        load_key(K1);
        data_in = P1;
        start = 1'b1;
        tick();
        data_in = P2;
        n = 0;
        while (!done && n < NR + 10) begin
            tick();
            n++;
        end
        chk("v4a latency", 128'(n), 128'(NR));
        chk("v4a data_out", data_out, C1);
        load_key(K2);
        tick();
        start = 1'b0;
        chk("v4 no bubble busy", 128'(busy), 128'(1));
        wait_done("v4b", 0, C2);

        launch(P1, K1);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        #1;
        chk("v5 rst busy", 128'(busy), 128'(0));
        chk("v5 rst done", 128'(done), 128'(0));
        chk("v5 rst data_out", data_out, '0);
        chk("v5 rst sbox_in", sbox_in, '0);
        tick();
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) nd++;
        end
        chk("v5 no done", 128'(nd), 128'(0));
        launch(P2, K2);
        wait_done("v5 restart", 0, C2);

        held = data_out;
        tick();
        ovr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = rand128();
            ovr_key = rand128();
            tick();
            chk("v6 hold data_out", data_out, held);
            chk("v6 hold done", 128'(done), 128'(0));
            chk("v6 hold busy", 128'(busy), 128'(0));
        end
        ovr = 1'b0;

        for (int i = 0; i < 4; i++) begin
            held = rand128();
            pk[0] = rand128();
            launch(pk[0], held);
            wait_done("rand", 0, aes_ref(pk[0], held));
            tick();
        end

        for (int i = 0; i < 3; i++) begin
            pk[i] = rand128();
            kk[i] = rand128();
        end
        load_key(kk[0]);
        data_in = pk[0];
        start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            start = (i < 2);
            if (i < 2) data_in = pk[i+1];
            n = 0;
            while (!done && n < NR + 10) begin
                tick();
                n++;
            end
            chk("b2b latency", 128'(n), 128'(NR));
            chk("b2b data_out", data_out, aes_ref(pk[i], kk[i]));
            if (i < 2) begin
                load_key(kk[i+1]);
                tick();
            end
        end
        start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
